// File: rtl/acq_trigger_gen.sv
// Acquisition trigger generator: turns timer ticks into delayed, fixed-width trigger pulses
// with burst counting. Optional pulse timestamping is enabled by defining ACQ_TRIG_TIMESTAMP_EN.
module acq_trigger_gen #(
  parameter logic [15:0] RESET_DELAY = 16'd0,
  parameter logic [15:0] RESET_WIDTH = 16'd4,
  parameter logic [15:0] RESET_BURST = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        trig_out,
  output logic        irq
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r;
  logic        tick_d_r;
  logic [15:0] delay_r;
  logic [15:0] width_r;
  logic [15:0] burst_r;
  logic        irq_en_r;
  logic        done_r;
  logic        overrun_r;
  logic [15:0] trig_count_r;
  logic [15:0] cnt_r;
  logic [15:0] width_sh_r;
  logic [15:0] burst_sh_r;
  logic        trig_out_r;
  logic [15:0] readdata_r;

  logic        wr_s;
  logic        edge_s;
  logic        start_s;
  logic        stop_s;
  logic        stat_wr_s;
  logic        busy_s;
  logic        pulse_start_s;
  logic        done_set_s;
  logic        ovr_set_s;
  logic [15:0] rdata_s;

  // A zero width still produces a one-cycle pulse.
  function automatic logic [15:0] pulse_len_m1(input logic [15:0] w);
    return (w == 16'd0) ? 16'd0 : (w - 16'd1);
  endfunction

  // Bus decode, edge detect and FSM event conditions.
  always_comb begin
    wr_s          = chipselect & ~write_n;
    edge_s        = tick_in & ~tick_d_r;
    start_s       = wr_s && (address == 3'd1) && writedata[2];
    stop_s        = wr_s && (address == 3'd1) && writedata[3];
    stat_wr_s     = wr_s && (address == 3'd0);
    busy_s        = (state_r == ST_DELAY) || (state_r == ST_PULSE);
    ovr_set_s     = edge_s & busy_s;
    pulse_start_s = !start_s && !stop_s &&
                    (((state_r == ST_ARMED) && edge_s && (delay_r == 16'd0)) ||
                     ((state_r == ST_DELAY) && (cnt_r == 16'd0)));
    done_set_s    = !start_s && !stop_s && (state_r == ST_PULSE) && (cnt_r == 16'd0) &&
                    (burst_sh_r != 16'd0) && (trig_count_r == burst_sh_r);
  end

  // Tick edge history and CPU-programmable configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_d_r <= 1'b0;
      delay_r  <= RESET_DELAY;
      width_r  <= RESET_WIDTH;
      burst_r  <= RESET_BURST;
      irq_en_r <= 1'b0;
    end else begin
      tick_d_r <= tick_in;
      if (wr_s) begin
        case (address)
          3'd1:    irq_en_r <= writedata[0];
          3'd2:    delay_r  <= writedata;
          3'd3:    width_r  <= writedata;
          3'd4:    burst_r  <= writedata;
          default: ;
        endcase
      end
    end
  end

  // Sticky status flags; a STATUS write in the same cycle as a set event wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else if (stat_wr_s) begin
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_r    <= done_r | done_set_s;
      overrun_r <= overrun_r | ovr_set_s;
    end
  end

  // Trigger sequencing FSM with registered trigger output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      trig_out_r   <= 1'b0;
      trig_count_r <= 16'd0;
      cnt_r        <= 16'd0;
      width_sh_r   <= 16'd0;
      burst_sh_r   <= 16'd0;
    end else if (start_s) begin
      state_r      <= ST_ARMED;
      trig_out_r   <= 1'b0;
      trig_count_r <= 16'd0;
    end else if (stop_s) begin
      state_r    <= ST_IDLE;
      trig_out_r <= 1'b0;
    end else begin
      if (pulse_start_s) begin
        trig_count_r <= trig_count_r + 16'd1;
      end
      case (state_r)
        ST_IDLE: trig_out_r <= 1'b0;
        ST_ARMED: begin
          if (edge_s) begin
            width_sh_r <= width_r;
            burst_sh_r <= burst_r;
            if (delay_r == 16'd0) begin
              state_r    <= ST_PULSE;
              trig_out_r <= 1'b1;
              cnt_r      <= pulse_len_m1(width_r);
            end else begin
              state_r <= ST_DELAY;
              cnt_r   <= delay_r - 16'd1;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_r == 16'd0) begin
            state_r    <= ST_PULSE;
            trig_out_r <= 1'b1;
            cnt_r      <= pulse_len_m1(width_sh_r);
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_PULSE: begin
          if (cnt_r == 16'd0) begin
            trig_out_r <= 1'b0;
            state_r    <= done_set_s ? ST_DONE : ST_ARMED;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_DONE: trig_out_r <= 1'b0;
        default: begin
          state_r    <= ST_IDLE;
          trig_out_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACQ_TRIG_TIMESTAMP_EN
  logic [31:0] ts_cnt_r;
  logic [31:0] ts_r;

  // Free-running time base, sampled on each pulse start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_r <= 32'd0;
      ts_r     <= 32'd0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 32'd1;
      if (pulse_start_s) begin
        ts_r <= ts_cnt_r;
      end
    end
  end
`endif

  // Read data selection.
  always_comb begin
    rdata_s = 16'd0;
    case (address)
      3'd0:    rdata_s = {13'd0, overrun_r, busy_s, done_r};
      3'd1:    rdata_s = {15'd0, irq_en_r};
      3'd2:    rdata_s = delay_r;
      3'd3:    rdata_s = width_r;
      3'd4:    rdata_s = burst_r;
      3'd5:    rdata_s = trig_count_r;
`ifdef ACQ_TRIG_TIMESTAMP_EN
      3'd6:    rdata_s = ts_r[15:0];
      3'd7:    rdata_s = ts_r[31:16];
`endif
      default: rdata_s = 16'd0;
    endcase
  end

  // Registered read port: data valid the cycle after the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= 16'd0;
    end else begin
      readdata_r <= rdata_s;
    end
  end

  assign readdata = readdata_r;
  assign trig_out = trig_out_r;
  assign irq      = (done_r | overrun_r) & irq_en_r;

endmodule

// File: tb/tb_acq_trigger_gen.sv
// Self-checking bench for acq_trigger_gen: register table readback plus trigger timing sequences.
module tb_acq_trigger_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_in = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        trig_out;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t        rst_tab[8];
  logic [15:0] rd_q[$];
  logic        trig_q[$];
  logic [15:0] ts_a, ts_b, ts_c, ts_d;

  acq_trigger_gen dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .trig_out(trig_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    chipselect = 1'b0;
    chk(name, readdata, rd_q.pop_front());
  endtask

  task automatic read_raw(input logic [2:0] a, output logic [15:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    v = readdata;
  endtask

  // bit i of ticks drives tick_in into edge i; bit i of exp is trig_out just after edge i
  task automatic run_seq(input logic [31:0] ticks, input logic [31:0] exp, input int len,
                         input string name);
    for (int i = 0; i < len; i++) begin
      tick_in = ticks[i];
      trig_q.push_back(exp[i]);
      @(posedge clk); #1;
      chk(name, {31'd0, trig_out}, {31'd0, trig_q.pop_front()});
    end
    tick_in = 1'b0;
  endtask

  task automatic check_reset_table();
    for (int i = 0; i < 8; i++) do_read(rst_tab[i].addr, rst_tab[i].exp, rst_tab[i].name);
    chk("rst_trig", {31'd0, trig_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
  endtask

  initial begin
    rst_tab[0] = '{3'd0, 16'd0, "rst_status"};
    rst_tab[1] = '{3'd1, 16'd0, "rst_control"};
    rst_tab[2] = '{3'd2, 16'd0, "rst_delay"};
    rst_tab[3] = '{3'd3, 16'd4, "rst_width"};
    rst_tab[4] = '{3'd4, 16'd0, "rst_burst"};
    rst_tab[5] = '{3'd5, 16'd0, "rst_count"};
    rst_tab[6] = '{3'd6, 16'd0, "rst_addr6"};
    rst_tab[7] = '{3'd7, 16'd0, "rst_addr7"};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_table();

    // IDLE ignores edges
    run_seq(32'h1, 32'h0, 4, "idle_ignore");

    // Delay 3, width 2
    do_write(3'd2, 16'd3);
    do_write(3'd3, 16'd2);
    do_write(3'd1, 16'h0004);
    run_seq(32'h1, 32'h18, 8, "d3w2_trig");
    do_read(3'd5, 16'd1, "d3w2_count");
    do_read(3'd0, 16'd0, "d3w2_status");

    // Burst of three, zero delay, width 1
    do_write(3'd2, 16'd0);
    do_write(3'd3, 16'd1);
    do_write(3'd4, 16'd3);
    do_write(3'd1, 16'h0005);
    do_read(3'd1, 16'd1, "ctrl_irq_en");
    run_seq(32'h111, 32'h111, 12, "burst_trig");
    chk("burst_irq", {31'd0, irq}, 32'd1);
    do_read(3'd0, 16'd1, "burst_done");
    do_read(3'd5, 16'd3, "burst_count");
    run_seq(32'h1, 32'h0, 4, "done_ignore");
    do_write(3'd0, 16'd0);
    chk("burst_irq_clr", {31'd0, irq}, 32'd0);

    // Overrun: second edge during the delay is discarded
    do_write(3'd2, 16'd10);
    do_write(3'd4, 16'd0);
    do_write(3'd1, 16'h0005);
    run_seq(32'h21, 32'h400, 14, "ovr_trig");
    do_read(3'd0, 16'h0004, "ovr_status");
    chk("ovr_irq", {31'd0, irq}, 32'd1);

    // STATUS write coinciding with an overrun event resolves to clear
    do_write(3'd0, 16'd0);
    tick_in = 1'b1; @(posedge clk); #1;
    tick_in = 1'b0; @(posedge clk); #1;
    tick_in = 1'b1;
    do_write(3'd0, 16'd0);
    tick_in = 1'b0;
    do_read(3'd0, 16'h0002, "ovr_clr_wins");
    repeat (14) @(posedge clk);
    #1;
    do_read(3'd0, 16'h0000, "ovr_clr_after");

    // Width 0 gives a one-cycle pulse
    do_write(3'd2, 16'd0);
    do_write(3'd3, 16'd0);
    do_write(3'd1, 16'h0004);
    run_seq(32'h1, 32'h1, 4, "w0_trig");

    // STOP mid-pulse
    do_write(3'd3, 16'd5);
    tick_in = 1'b1; @(posedge clk); #1;
    tick_in = 1'b0;
    chk("stop_pre", {31'd0, trig_out}, 32'd1);
    do_write(3'd1, 16'h0008);
    chk("stop_trig", {31'd0, trig_out}, 32'd0);
    do_read(3'd0, 16'h0000, "stop_status");
    run_seq(32'h1, 32'h0, 8, "stop_ignore");

    // START and STOP together arms
    do_write(3'd1, 16'h000C);
    run_seq(32'h1, 32'h1F, 8, "startstop_trig");

`ifdef ACQ_TRIG_TIMESTAMP_EN
    do_write(3'd3, 16'd1);
    tick_in = 1'b1; @(posedge clk); #1;
    tick_in = 1'b0;
    read_raw(3'd6, ts_a);
    read_raw(3'd7, ts_b);
    repeat (997) @(posedge clk);
    #1 tick_in = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0;
    read_raw(3'd6, ts_c);
    read_raw(3'd7, ts_d);
    chk("ts_delta", {ts_d, ts_c} - {ts_b, ts_a}, 32'd1000);
`else
    do_read(3'd6, 16'd0, "addr6_zero");
    do_read(3'd7, 16'd0, "addr7_zero");
`endif

    // Reset asserted mid-pulse
    do_write(3'd3, 16'd5);
    do_write(3'd2, 16'd7);
    do_write(3'd1, 16'h0005);
    do_write(3'd2, 16'd0);
    tick_in = 1'b1; @(posedge clk); #1;
    tick_in = 1'b0;
    chk("mid_rst_pre", {31'd0, trig_out}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_trig", {31'd0, trig_out}, 32'd0);
    reset = 1'b0;
    check_reset_table();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
